// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the five-stage core.
// Accepts retiring instructions from the memory stage, waits for the load
// response where needed, formats load data and drives the GPR and CSR write
// ports of the register file. The GPR write port also serves as the WB-to-EX
// forwarding source.
// Optional feature: define WB_INSTRET_EN to build the 64-bit retired-instruction
// counter; otherwise instret_o is tied to zero.
module wb_stage #(
   parameter int REG_BUS_WIDTH  = 5,
   parameter int DATA_BUS_WIDTH = 32,
   parameter int CSR_BUS_WIDTH  = 12
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      mem_vld_i,
   output logic                      mem_rdy_o,
   input  logic [REG_BUS_WIDTH-1:0]  mem_rd_addr_i,
   input  logic                      mem_rd_we_i,
   input  logic [DATA_BUS_WIDTH-1:0] mem_alu_result_i,
   input  logic                      mem_is_load_i,
   input  logic [2:0]                mem_ld_type_i,
   input  logic [1:0]                mem_byte_off_i,
   input  logic                      mem_csr_we_i,
   input  logic [CSR_BUS_WIDTH-1:0]  mem_csr_addr_i,
   input  logic [DATA_BUS_WIDTH-1:0] mem_csr_wdata_i,
   input  logic                      dmem_rvld_i,
   input  logic [DATA_BUS_WIDTH-1:0] dmem_rdata_i,
   output logic [REG_BUS_WIDTH-1:0]  reg_waddr_o,
   output logic                      reg_waddr_vld_o,
   output logic [DATA_BUS_WIDTH-1:0] reg_wdata_o,
   output logic [CSR_BUS_WIDTH-1:0]  csr_waddr_o,
   output logic                      csr_waddr_vld_o,
   output logic [DATA_BUS_WIDTH-1:0] csr_wdata_o,
   output logic [63:0]               instret_o
);

   typedef enum logic [1:0] {
      S_EMPTY  = 2'd0,
      S_WAIT   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [REG_BUS_WIDTH-1:0]  rd_addr_q;
   logic                      rd_we_q;
   logic [DATA_BUS_WIDTH-1:0] wdata_q;
   logic [2:0]                ld_type_q;
   logic [1:0]                byte_off_q;
   logic                      csr_we_q;
   logic [CSR_BUS_WIDTH-1:0]  csr_addr_q;
   logic [DATA_BUS_WIDTH-1:0] csr_wdata_q;

   logic                      accept;
   logic [7:0]                ld_byte;
   logic [15:0]               ld_half;
   logic [DATA_BUS_WIDTH-1:0] ld_data;

   // Ready depends on state alone so there is no combinational loop back to the memory stage
   assign mem_rdy_o = (state_q != S_WAIT);
   assign accept    = mem_vld_i & mem_rdy_o;

   // State register; reset drops any pending load
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: accept from EMPTY/COMMIT, loads park in WAIT until the response pulse
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_EMPTY, S_COMMIT: begin
            if (accept) begin
               state_d = mem_is_load_i ? S_WAIT : S_COMMIT;
            end else begin
               state_d = S_EMPTY;
            end
         end
         S_WAIT: begin
            if (dmem_rvld_i) begin
               state_d = S_COMMIT;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   // Load formatting from the latched funct3 and byte offset of the raw aligned word
   always_comb begin
      ld_byte = 8'h00;
      ld_half = 16'h0000;
      ld_data = dmem_rdata_i;
      case (byte_off_q)
         2'd0:    ld_byte = dmem_rdata_i[7:0];
         2'd1:    ld_byte = dmem_rdata_i[15:8];
         2'd2:    ld_byte = dmem_rdata_i[23:16];
         default: ld_byte = dmem_rdata_i[31:24];
      endcase
      ld_half = byte_off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      case (ld_type_q)
         3'b000:  ld_data = {{(DATA_BUS_WIDTH-8){ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {{(DATA_BUS_WIDTH-8){1'b0}}, ld_byte};
         3'b001:  ld_data = {{(DATA_BUS_WIDTH-16){ld_half[15]}}, ld_half};
         3'b101:  ld_data = {{(DATA_BUS_WIDTH-16){1'b0}}, ld_half};
         default: ld_data = dmem_rdata_i;
      endcase
   end

   // Entry latch: fields captured on accept, GPR data replaced by the formatted load response
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_addr_q   <= '0;
         rd_we_q     <= 1'b0;
         wdata_q     <= '0;
         ld_type_q   <= 3'b000;
         byte_off_q  <= 2'b00;
         csr_we_q    <= 1'b0;
         csr_addr_q  <= '0;
         csr_wdata_q <= '0;
      end else if (accept) begin
         rd_addr_q   <= mem_rd_addr_i;
         rd_we_q     <= mem_rd_we_i;
         wdata_q     <= mem_alu_result_i;
         ld_type_q   <= mem_ld_type_i;
         byte_off_q  <= mem_byte_off_i;
         csr_we_q    <= mem_csr_we_i;
         csr_addr_q  <= mem_csr_addr_i;
         csr_wdata_q <= mem_csr_wdata_i;
      end else if ((state_q == S_WAIT) && dmem_rvld_i) begin
         wdata_q     <= ld_data;
      end
   end

   assign reg_waddr_o     = rd_addr_q;
   assign reg_wdata_o     = wdata_q;
   assign reg_waddr_vld_o = (state_q == S_COMMIT) && rd_we_q && (rd_addr_q != '0);
   assign csr_waddr_o     = csr_addr_q;
   assign csr_wdata_o     = csr_wdata_q;
   assign csr_waddr_vld_o = (state_q == S_COMMIT) && csr_we_q;

`ifdef WB_INSTRET_EN
   logic [63:0] instret_q;

   // Retired-instruction counter: one per commit cycle, wrapping naturally at 2^64
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         instret_q <= 64'd0;
      end else if (state_q == S_COMMIT) begin
         instret_q <= instret_q + 64'd1;
      end
   end

   assign instret_o = instret_q;
`else
   assign instret_o = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and randomized checks of the writeback stage against
// a small behavioural model of load formatting and commit behaviour.
module tb_wb_stage;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        mem_vld_i;
   logic        mem_rdy_o;
   logic [4:0]  mem_rd_addr_i;
   logic        mem_rd_we_i;
   logic [31:0] mem_alu_result_i;
   logic        mem_is_load_i;
   logic [2:0]  mem_ld_type_i;
   logic [1:0]  mem_byte_off_i;
   logic        mem_csr_we_i;
   logic [11:0] mem_csr_addr_i;
   logic [31:0] mem_csr_wdata_i;
   logic        dmem_rvld_i;
   logic [31:0] dmem_rdata_i;
   logic [4:0]  reg_waddr_o;
   logic        reg_waddr_vld_o;
   logic [31:0] reg_wdata_o;
   logic [11:0] csr_waddr_o;
   logic        csr_waddr_vld_o;
   logic [31:0] csr_wdata_o;
   logic [63:0] instret_o;

   int checks = 0;
   int errors = 0;
   longint unsigned retired = 0;

   wb_stage dut (
      .clk_i            (clk_i),
      .rst_n_i          (rst_n_i),
      .mem_vld_i        (mem_vld_i),
      .mem_rdy_o        (mem_rdy_o),
      .mem_rd_addr_i    (mem_rd_addr_i),
      .mem_rd_we_i      (mem_rd_we_i),
      .mem_alu_result_i (mem_alu_result_i),
      .mem_is_load_i    (mem_is_load_i),
      .mem_ld_type_i    (mem_ld_type_i),
      .mem_byte_off_i   (mem_byte_off_i),
      .mem_csr_we_i     (mem_csr_we_i),
      .mem_csr_addr_i   (mem_csr_addr_i),
      .mem_csr_wdata_i  (mem_csr_wdata_i),
      .dmem_rvld_i      (dmem_rvld_i),
      .dmem_rdata_i     (dmem_rdata_i),
      .reg_waddr_o      (reg_waddr_o),
      .reg_waddr_vld_o  (reg_waddr_vld_o),
      .reg_wdata_o      (reg_wdata_o),
      .csr_waddr_o      (csr_waddr_o),
      .csr_waddr_vld_o  (csr_waddr_vld_o),
      .csr_wdata_o      (csr_wdata_o),
      .instret_o        (instret_o)
   );

   // Free-running clock, 10 time units per period
   always #5 clk_i = ~clk_i;

   // Watchdog so a stuck run still reports and ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference load formatting computed with plain shifts and arithmetic
   function automatic logic [31:0] refLoad(input logic [2:0] t, input logic [1:0] off,
                                           input logic [31:0] w);
      longint unsigned b, h;
      b = (longint'(w) >> (8 * off)) % 256;
      h = (longint'(w) >> (16 * (off / 2))) % 65536;
      case (t)
         3'b000:  return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
         3'b100:  return 32'(b);
         3'b001:  return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
         3'b101:  return 32'(h);
         default: return w;
      endcase
   endfunction

   function automatic logic [63:0] expInstret(input longint unsigned n);
`ifdef WB_INSTRET_EN
      return 64'(n);
`else
      return 64'(n & 0);
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic vld, input logic [4:0] rd, input logic we,
                                input logic [31:0] alu, input logic isLoad,
                                input logic [2:0] ldType, input logic [1:0] off,
                                input logic csrWe, input logic [11:0] csrAddr,
                                input logic [31:0] csrData);
      mem_vld_i        = vld;
      mem_rd_addr_i    = rd;
      mem_rd_we_i      = we;
      mem_alu_result_i = alu;
      mem_is_load_i    = isLoad;
      mem_ld_type_i    = ldType;
      mem_byte_off_i   = off;
      mem_csr_we_i     = csrWe;
      mem_csr_addr_i   = csrAddr;
      mem_csr_wdata_i  = csrData;
   endtask

   // Checks one commit cycle; addr/data are only compared when the strobe is expected
   task automatic checkCommit(input string tag, input logic [4:0] rd, input logic we,
                              input logic [31:0] data, input logic csrWe,
                              input logic [11:0] csrAddr, input logic [31:0] csrData);
      logic expVld;
      expVld = we && (rd != 5'd0);
      checkOutput({tag, ".reg_vld"}, 64'(reg_waddr_vld_o), 64'(expVld));
      if (expVld) begin
         checkOutput({tag, ".reg_addr"}, 64'(reg_waddr_o), 64'(rd));
         checkOutput({tag, ".reg_data"}, 64'(reg_wdata_o), 64'(data));
      end
      checkOutput({tag, ".csr_vld"}, 64'(csr_waddr_vld_o), 64'(csrWe));
      if (csrWe) begin
         checkOutput({tag, ".csr_addr"}, 64'(csr_waddr_o), 64'(csrAddr));
         checkOutput({tag, ".csr_data"}, 64'(csr_wdata_o), 64'(csrData));
      end
      checkOutput({tag, ".rdy"}, 64'(mem_rdy_o), 64'd1);
      checkOutput({tag, ".instret"}, instret_o, expInstret(retired));
      retired++;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, ".reg_vld"}, 64'(reg_waddr_vld_o), 64'd0);
      checkOutput({tag, ".csr_vld"}, 64'(csr_waddr_vld_o), 64'd0);
      checkOutput({tag, ".rdy"}, 64'(mem_rdy_o), 64'd1);
      checkOutput({tag, ".instret"}, instret_o, expInstret(retired));
   endtask

   // Issues a load, holds off the response for waitCycles-1 cycles, then checks the commit
   task automatic runLoad(input string tag, input logic [4:0] rd, input logic [2:0] t,
                          input logic [1:0] off, input logic [31:0] word, input int waitCycles);
      applyStimulus(1'b1, rd, 1'b1, 32'hDEAD_BEEF, 1'b1, t, off, 1'b0, 12'h0, 32'h0);
      step();
      mem_vld_i = 1'b0;
      for (int j = 0; j < waitCycles - 1; j++) begin
         checkOutput({tag, ".wait_rdy"}, 64'(mem_rdy_o), 64'd0);
         checkOutput({tag, ".wait_vld"}, 64'(reg_waddr_vld_o), 64'd0);
         step();
      end
      checkOutput({tag, ".wait_rdy"}, 64'(mem_rdy_o), 64'd0);
      dmem_rvld_i  = 1'b1;
      dmem_rdata_i = word;
      step();
      dmem_rvld_i  = 1'b0;
      dmem_rdata_i = $urandom;
      checkCommit(tag, rd, 1'b1, refLoad(t, off, word), 1'b0, 12'h0, 32'h0);
      step();
      checkIdle({tag, ".after"});
   endtask

   initial begin
      logic [31:0] word;
      logic [4:0]  rd;
      logic        we;
      logic        csrWe;
      logic [11:0] csrAddr;
      logic [31:0] alu;
      logic [31:0] csrData;

      rst_n_i      = 1'b0;
      dmem_rvld_i  = 1'b0;
      dmem_rdata_i = 32'h0;
      applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 3'b000, 2'b00, 1'b0, 12'h0, 32'h0);
      #12;
      checkIdle("reset");
      checkOutput("reset.reg_addr", 64'(reg_waddr_o), 64'd0);
      checkOutput("reset.reg_data", 64'(reg_wdata_o), 64'd0);
      checkOutput("reset.csr_addr", 64'(csr_waddr_o), 64'd0);
      checkOutput("reset.csr_data", 64'(csr_wdata_o), 64'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      $display("[TB] reset released");

      // Three back-to-back non-loads, one commit per cycle
      applyStimulus(1'b1, 5'd1, 1'b1, 32'h11, 1'b0, 3'b010, 2'b00, 1'b0, 12'h0, 32'h0);
      step();
      checkCommit("b2b1", 5'd1, 1'b1, 32'h11, 1'b0, 12'h0, 32'h0);
      applyStimulus(1'b1, 5'd2, 1'b1, 32'h22, 1'b0, 3'b010, 2'b00, 1'b0, 12'h0, 32'h0);
      step();
      checkCommit("b2b2", 5'd2, 1'b1, 32'h22, 1'b0, 12'h0, 32'h0);
      applyStimulus(1'b1, 5'd3, 1'b1, 32'h33, 1'b0, 3'b010, 2'b00, 1'b0, 12'h0, 32'h0);
      step();
      checkCommit("b2b3", 5'd3, 1'b1, 32'h33, 1'b0, 12'h0, 32'h0);
      mem_vld_i = 1'b0;
      step();
      checkIdle("b2b_idle");

      // Directed loads with a four-cycle gap before the response
      runLoad("lb_off3", 5'd7, 3'b000, 2'd3, 32'h80FF_0000, 5);
      checkOutput("lb_ref", 64'(refLoad(3'b000, 2'd3, 32'h80FF_0000)), 64'hFFFF_FF80);
      runLoad("lhu_off2", 5'd8, 3'b101, 2'd2, 32'h80FF_0000, 5);

      // Stray response while empty must not produce a write
      dmem_rvld_i  = 1'b1;
      dmem_rdata_i = 32'h1234_5678;
      step();
      dmem_rvld_i  = 1'b0;
      checkIdle("stray_rvld");

      // Response coincident with the accepting edge is not observed
      applyStimulus(1'b1, 5'd9, 1'b1, 32'h0, 1'b1, 3'b010, 2'b00, 1'b0, 12'h0, 32'h0);
      dmem_rvld_i  = 1'b1;
      dmem_rdata_i = 32'hAAAA_AAAA;
      step();
      mem_vld_i   = 1'b0;
      dmem_rvld_i = 1'b0;
      checkOutput("same_edge.rdy", 64'(mem_rdy_o), 64'd0);
      step();
      checkOutput("same_edge.still_wait", 64'(mem_rdy_o), 64'd0);
      checkOutput("same_edge.no_vld", 64'(reg_waddr_vld_o), 64'd0);
      dmem_rvld_i  = 1'b1;
      dmem_rdata_i = 32'h5555_0001;
      step();
      dmem_rvld_i = 1'b0;
      checkCommit("same_edge", 5'd9, 1'b1, 32'h5555_0001, 1'b0, 12'h0, 32'h0);
      step();
      checkIdle("same_edge.after");

      // rd = x0 is never written but still retires
      applyStimulus(1'b1, 5'd0, 1'b1, 32'hCAFE, 1'b0, 3'b010, 2'b00, 1'b0, 12'h0, 32'h0);
      step();
      mem_vld_i = 1'b0;
      checkCommit("rd0", 5'd0, 1'b1, 32'hCAFE, 1'b0, 12'h0, 32'h0);
      step();
      checkIdle("rd0.after");

      // CSR write with GPR write of the old value in the same cycle
      applyStimulus(1'b1, 5'd5, 1'b1, 32'h100, 1'b0, 3'b010, 2'b00, 1'b1, 12'h305,
                    32'h8000_0000);
      step();
      mem_vld_i = 1'b0;
      checkCommit("csr", 5'd5, 1'b1, 32'h100, 1'b1, 12'h305, 32'h8000_0000);
      step();
      checkIdle("csr.after");

      // Randomized mix of loads and non-loads
      for (int i = 0; i < 24; i++) begin
         rd   = 5'($urandom_range(0, 31));
         word = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            runLoad("rand_ld", rd, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), word,
                    int'($urandom_range(1, 3)));
         end else begin
            we      = 1'($urandom_range(0, 1));
            csrWe   = 1'($urandom_range(0, 1));
            csrAddr = 12'($urandom);
            alu     = $urandom;
            csrData = $urandom;
            applyStimulus(1'b1, rd, we, alu, 1'b0, 3'($urandom_range(0, 7)), 2'($urandom),
                          csrWe, csrAddr, csrData);
            step();
            mem_vld_i = 1'b0;
            checkCommit("rand_alu", rd, we, alu, csrWe, csrAddr, csrData);
            step();
            checkIdle("rand_alu.after");
         end
      end

      // Reset while a load is pending: the later response must be ignored
      applyStimulus(1'b1, 5'd10, 1'b1, 32'h0, 1'b1, 3'b010, 2'b00, 1'b1, 12'h300, 32'h1);
      step();
      mem_vld_i = 1'b0;
      checkOutput("rst_wait.rdy", 64'(mem_rdy_o), 64'd0);
      rst_n_i = 1'b0;
      #2;
      retired = 0;
      checkOutput("rst_wait.rdy_async", 64'(mem_rdy_o), 64'd1);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      dmem_rvld_i  = 1'b1;
      dmem_rdata_i = 32'hFFFF_FFFF;
      step();
      dmem_rvld_i = 1'b0;
      checkIdle("rst_wait.after");
      checkOutput("rst_wait.instret0", instret_o, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage core. It accepts retiring instructions from the memory stage over a valid/ready handshake and waits for the data-memory response on loads. It extracts and sign/zero-extends load data, then drives the single GPR write port and the CSR write port of `regfile`. Its write port doubles as the WB-to-EX forwarding source.

## Interface
Parameters (from `param.v`):
- `REG_BUS_WIDTH`, 5, GPR index width
- `DATA_BUS_WIDTH`, 32, datapath width
- `CSR_BUS_WIDTH`, 12, CSR address width

Ports:
- `clk_i`  in  1  core clock, all state updates on rising edge
- `rst_n_i`  in  1  reset; asynchronous, active-low
- `mem_vld_i`  in  1  memory stage holds a retiring instruction
- `mem_rdy_o`  out  1  stage can accept this cycle
- `mem_rd_addr_i`  in  REG_BUS_WIDTH  destination GPR
- `mem_rd_we_i`  in  1  instruction writes a GPR
- `mem_alu_result_i`  in  DATA_BUS_WIDTH  non-load writeback value
- `mem_is_load_i`  in  1  instruction is a load
- `mem_ld_type_i`  in  3  load funct3
- `mem_byte_off_i`  in  2  address bits [1:0] of the load
- `mem_csr_we_i`  in  1  instruction writes a CSR
- `mem_csr_addr_i`  in  CSR_BUS_WIDTH  CSR write address
- `mem_csr_wdata_i`  in  DATA_BUS_WIDTH  CSR write value
- `dmem_rvld_i`  in  1  load response valid, single-cycle pulse
- `dmem_rdata_i`  in  DATA_BUS_WIDTH  raw aligned word
- `reg_waddr_o`  out  REG_BUS_WIDTH  to `reg_waddr_i`
- `reg_waddr_vld_o`  out  1  to `reg_waddr_vld_i`; also forwarding valid
- `reg_wdata_o`  out  DATA_BUS_WIDTH  to `reg_wdata_i`
- `csr_waddr_o`  out  CSR_BUS_WIDTH  to `csr_waddr_i`
- `csr_waddr_vld_o`  out  1  to `csr_waddr_vld_i`
- `csr_wdata_o`  out  DATA_BUS_WIDTH  to `csr_wdata_i`
- `instret_o`  out  64  retired-instruction count

## Operation
- FSM states:
  - S_EMPTY: `mem_rdy_o`=1.
  - S_WAIT: `mem_rdy_o`=0.
  - S_COMMIT: `mem_rdy_o`=1.
- Accept when `mem_vld_i & mem_rdy_o`; all `mem_*` fields are latched.
- On accept, a load goes to S_WAIT and a non-load goes to S_COMMIT.
- From S_COMMIT with no accept, go to S_EMPTY.
- In S_WAIT, `dmem_rvld_i` latches the formatted load data and moves to S_COMMIT.
- `dmem_rvld_i` outside S_WAIT is ignored.
- Load formatting:
  - 000 lb: byte at `off`, sign-extended.
  - 100 lbu: byte at `off`, zero-extended.
  - 001 lh: halfword at `off[1]`, sign-extended.
  - 101 lhu: halfword at `off[1]`, zero-extended.
  - 010 and all other codes: full word.
  - `off[0]` is ignored for halfwords; `off` is ignored for words.
- `reg_waddr_vld_o` = S_COMMIT & rd_we & (rd != 0).
- `csr_waddr_vld_o` = S_COMMIT & csr_we.
- A CSR instruction with rd_we asserts both strobes in the same cycle. GPR data is `mem_alu_result_i` (the old CSR value); CSR data is `mem_csr_wdata_i`.
- Address and data outputs always reflect the latched entry. They are don't-care when the strobe is low, but are reset to 0.

## Timing
- Reset values:
  - state = S_EMPTY, so `mem_rdy_o`=1.
  - All strobes = 0.
  - All address and data outputs = 0.
  - `instret_o` = 0.
- Reset mid-operation: a pending load is dropped, and its later `dmem_rvld_i` is ignored (state S_EMPTY).
- Non-load accepted at edge N: strobes high during cycle N+1; `regfile` writes at edge N+1.
- Load: `dmem_rvld_i` high in cycle k, strobes high in cycle k+1.
- `dmem_rvld_i` in the same cycle as the accepting edge is not observed; the response must arrive at least one cycle after accept.
- Back-to-back non-loads give one commit per cycle. Accepting in S_COMMIT overwrites the entry at the same edge the current commit completes.
- `mem_rdy_o` is a function of state only, with no combinational path from `mem_vld_i` or `dmem_rvld_i`.

## Configuration
- `WB_INSTRET_EN` defined:
  - 64-bit counter increments by 1 on each S_COMMIT cycle, including rd=x0 and no-write instructions.
  - Wraps modulo 2^64.
- `WB_INSTRET_EN` undefined: no counter is built; `instret_o` is tied to 0.

## Test plan
- Reset then three back-to-back non-loads to rd=1,2,3 with data 0x11, 0x22, 0x33: three consecutive cycles of `reg_waddr_vld_o`=1 with matching addr/data; `mem_rdy_o` stays 1.
- lb at off=3 with `dmem_rdata_i`=0x80FF_0000 after 4 wait cycles: `mem_rdy_o`=0 while waiting; commit next cycle with 0xFFFF_FF80. Same word with lhu at off=2: 0x0000_80FF.
- Non-load with rd=0, rd_we=1: `reg_waddr_vld_o` stays 0. With `WB_INSTRET_EN`, `instret_o` increments by 1.
- CSR write to 0x305 with wdata 0x8000_0000 and rd=5 with old value 0x100: both strobes high in the same cycle with the correct addr/data.
- Assert `rst_n_i` while in S_WAIT, release, then pulse `dmem_rvld_i`: no write strobe; `mem_rdy_o`=1 and `instret_o`=0.
